// File: rtl/pio_cmd_pkg.sv
// pio_cmd_pkg
//   Shared constants and types for the PIO command capture block.
//   TOGGLE_BIT    : bit of the PIO word used as the toggle strobe
//   PAYLOAD_W     : width of the command payload (bits below the strobe)
//   DEFAULT_DEPTH : default command FIFO depth
//   DEFAULT_CNT_W : default overflow counter width
package pio_cmd_pkg;

    localparam int TOGGLE_BIT    = 31;
    localparam int PAYLOAD_W     = 31;
    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_CNT_W = 8;

    typedef logic [PAYLOAD_W-1:0] payload_t;

endpackage

// File: rtl/pio_cmd_fifo.sv
// pio_cmd_fifo
//   Synchronous show-ahead FIFO holding captured command payloads.
//   The head entry is presented combinationally on o_data whenever the
//   FIFO is non-empty. A push while full is accepted only if a pop happens
//   on the same edge; callers decide what to do with rejected pushes.
// Ports:
//   clk     : clock, all state updates on rising edge
//   reset   : synchronous active-high reset (pointers and level only)
//   i_push  : write request
//   i_data  : payload written on an accepted push
//   i_pop   : read request, ignored while empty
//   o_data  : head-of-FIFO payload
//   o_full  : FIFO holds DEPTH entries
//   o_empty : FIFO holds no entries
//   o_level : number of entries held, 0..DEPTH
module pio_cmd_fifo
    import pio_cmd_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  payload_t                 i_data,
    input  logic                     i_pop,
    output payload_t                 o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    payload_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_count;

    logic            w_do_push;
    logic            w_do_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == LW'(DEPTH));

    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; entries are only visible through the level.
    always_ff @(posedge clk) begin
        if (w_do_push && !reset) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_count;

endmodule

// File: rtl/pio_cmd_capture.sv
// pio_cmd_capture
//   Turns toggle-strobed PIO output words into a queue of commands.
//   Every change of the strobe bit relative to its value on the previous
//   cycle is one command; its payload is pushed into a show-ahead FIFO.
//   Commands arriving while the FIFO is full (and not draining on the same
//   edge) are dropped and counted in a saturating overflow counter.
// Ports:
//   clk          : sole clock
//   reset        : synchronous active-high reset
//   pio_word     : PIO word, bit 31 toggle strobe, bits 30:0 payload
//   cmd_data     : head-of-FIFO payload, valid while cmd_valid=1
//   cmd_valid    : FIFO non-empty
//   cmd_ready    : consumer takes the head entry this cycle
//   fifo_level   : current number of queued commands
//   overflow_cnt : number of dropped commands, saturating
module pio_cmd_capture
    import pio_cmd_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              pio_word,
    output logic [PAYLOAD_W-1:0]     cmd_data,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         overflow_cnt
);

    logic               r_prev_tog;
    logic [CNT_W-1:0]   r_overflow_cnt;

    logic               w_event;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;
    payload_t           w_payload;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == {CNT_W{1'b1}}) begin
            return val;
        end
        return val + CNT_W'(1);
    endfunction

    // Reset value 0 matches the upstream PIO, so a first strobe of 1 after
    // reset is a genuine command.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_tog <= 1'b0;
        end else begin
            r_prev_tog <= pio_word[TOGGLE_BIT];
        end
    end

    assign w_payload = pio_word[PAYLOAD_W-1:0];
    assign w_event   = (pio_word[TOGGLE_BIT] != r_prev_tog) && !reset;
    assign w_pop     = cmd_valid && cmd_ready;
    assign w_drop    = w_event && w_full && !w_pop;

    pio_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_event),
        .i_data  (w_payload),
        .i_pop   (cmd_ready),
        .o_data  (cmd_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow_cnt <= '0;
        end else if (w_drop) begin
            r_overflow_cnt <= sat_inc(r_overflow_cnt);
        end
    end

    assign cmd_valid    = !w_empty;
    assign overflow_cnt = r_overflow_cnt;

endmodule

// File: tb/tb_pio_cmd_capture.sv
module tb_pio_cmd_capture;

    localparam int DEPTH  = 8;
    localparam int CNT_W  = 8;
    localparam int MAXOVF = (1 << CNT_W) - 1;

    logic                      clk;
    logic                      reset;
    logic [31:0]               pio_word;
    logic [30:0]               cmd_data;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [$clog2(DEPTH):0]    fifo_level;
    logic [CNT_W-1:0]          overflow_cnt;

    pio_cmd_capture #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pio_word     (pio_word),
        .cmd_data     (cmd_data),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .fifo_level   (fifo_level),
        .overflow_cnt (overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of pending commands, the last strobe level
    // seen, and the saturating drop count.
    logic [30:0] m_q[$];
    logic        m_prev;
    int          m_ovf;

    int n_vec;
    int n_err;

    // Apply one cycle of inputs, advance the model by the rules of the
    // block, then wait past the clock edge.
    task automatic drive(input logic [31:0] w, input logic rdy, input logic rst);
        logic        pop;
        logic        ev;
        logic [30:0] tmp;
        pio_word  = w;
        cmd_ready = rdy;
        reset     = rst;
        if (rst) begin
            m_q.delete();
            m_prev = 1'b0;
            m_ovf  = 0;
        end else begin
            pop = (m_q.size() != 0) && rdy;
            ev  = (w[31] != m_prev);
            if (pop) tmp = m_q.pop_front();
            if (ev) begin
                if (m_q.size() < DEPTH) m_q.push_back(w[30:0]);
                else if (m_ovf < MAXOVF) m_ovf++;
            end
            m_prev = w[31];
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ev_word(input logic [30:0] p);
        return {~m_prev, p};
    endfunction

    function automatic logic [31:0] hold_word(input logic [30:0] p);
        return {m_prev, p};
    endfunction

    task automatic test_reset();
        drive(32'h8000_0000, 1'b0, 1'b1);
        drive(32'h0000_0000, 1'b1, 1'b1);
        n_vec++;
        if (cmd_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %0b expected 0", cmd_valid);
        end
        n_vec++;
        if (fifo_level !== 0) begin
            n_err++; $display("FAIL reset_level: got %0d expected 0", fifo_level);
        end
        n_vec++;
        if (overflow_cnt !== 0) begin
            n_err++; $display("FAIL reset_ovf: got %0d expected 0", overflow_cnt);
        end
        drive(32'h0000_0000, 1'b0, 1'b0);
    endtask

    task automatic test_basic();
        drive(32'h8000_0123, 1'b0, 1'b0);
        n_vec++;
        if (cmd_valid !== 1'b1 || cmd_data !== 31'h123 || fifo_level !== 1) begin
            n_err++;
            $display("FAIL basic_push: got valid=%0b data=%h level=%0d expected valid=1 data=123 level=1",
                     cmd_valid, cmd_data, fifo_level);
        end
        drive(32'h8000_0123, 1'b1, 1'b0);
        n_vec++;
        if (cmd_valid !== 1'b0 || fifo_level !== 0) begin
            n_err++;
            $display("FAIL basic_pop: got valid=%0b level=%0d expected valid=0 level=0",
                     cmd_valid, fifo_level);
        end
    endtask

    task automatic test_payload_hold();
        drive(hold_word(31'h123), 1'b0, 1'b0);
        drive(hold_word(31'h456), 1'b0, 1'b0);
        n_vec++;
        if (fifo_level !== 0 || cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL hold_empty: got level=%0d valid=%0b expected level=0 valid=0",
                     fifo_level, cmd_valid);
        end
        drive(ev_word(31'h77), 1'b0, 1'b0);
        drive(hold_word(31'h456), 1'b0, 1'b0);
        drive(hold_word(31'h789), 1'b0, 1'b0);
        n_vec++;
        if (fifo_level !== 1 || cmd_data !== 31'h77) begin
            n_err++;
            $display("FAIL hold_one: got level=%0d data=%h expected level=1 data=77",
                     fifo_level, cmd_data);
        end
        drive(hold_word(31'h789), 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 10; i++) drive(ev_word(31'(i)), 1'b0, 1'b0);
        n_vec++;
        if (fifo_level !== 8 || overflow_cnt !== 2) begin
            n_err++;
            $display("FAIL ovf_fill: got level=%0d ovf=%0d expected level=8 ovf=2",
                     fifo_level, overflow_cnt);
        end
        for (int i = 1; i <= 8; i++) begin
            n_vec++;
            if (cmd_valid !== 1'b1 || cmd_data !== 31'(i)) begin
                n_err++;
                $display("FAIL ovf_drain: got valid=%0b data=%0d expected valid=1 data=%0d",
                         cmd_valid, cmd_data, i);
            end
            drive(hold_word(31'h0), 1'b1, 1'b0);
        end
        n_vec++;
        if (cmd_valid !== 1'b0 || overflow_cnt !== 2) begin
            n_err++;
            $display("FAIL ovf_end: got valid=%0b ovf=%0d expected valid=0 ovf=2",
                     cmd_valid, overflow_cnt);
        end
    endtask

    task automatic test_full_pushpop();
        for (int i = 1; i <= 8; i++) drive(ev_word(31'(100 + i)), 1'b0, 1'b0);
        drive(ev_word(31'd999), 1'b1, 1'b0);
        n_vec++;
        if (fifo_level !== 8 || overflow_cnt !== 2 || cmd_data !== 31'd102) begin
            n_err++;
            $display("FAIL full_pp: got level=%0d ovf=%0d head=%0d expected level=8 ovf=2 head=102",
                     fifo_level, overflow_cnt, cmd_data);
        end
        for (int i = 2; i <= 9; i++) begin
            n_vec++;
            if (cmd_data !== ((i == 9) ? 31'd999 : 31'(100 + i))) begin
                n_err++;
                $display("FAIL full_pp_order: got %0d expected %0d",
                         cmd_data, (i == 9) ? 999 : 100 + i);
            end
            drive(hold_word(31'h0), 1'b1, 1'b0);
        end
    endtask

    task automatic test_empty_pushpop();
        n_vec++;
        if (cmd_valid !== 1'b0) begin
            n_err++; $display("FAIL empty_pre: got valid=%0b expected 0", cmd_valid);
        end
        drive(ev_word(31'h55), 1'b1, 1'b0);
        n_vec++;
        if (fifo_level !== 1 || cmd_valid !== 1'b1 || cmd_data !== 31'h55) begin
            n_err++;
            $display("FAIL empty_pp: got level=%0d valid=%0b data=%h expected level=1 valid=1 data=55",
                     fifo_level, cmd_valid, cmd_data);
        end
        drive(hold_word(31'h0), 1'b1, 1'b0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < DEPTH + MAXOVF + 10; i++) drive(ev_word(31'(i)), 1'b0, 1'b0);
        n_vec++;
        if (overflow_cnt !== CNT_W'(MAXOVF) || fifo_level !== 8) begin
            n_err++;
            $display("FAIL saturate: got ovf=%0d level=%0d expected ovf=%0d level=8",
                     overflow_cnt, fifo_level, MAXOVF);
        end
    endtask

    task automatic test_reset_mid();
        drive(32'h0, 1'b0, 1'b1);
        drive(32'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) drive(ev_word(31'(i)), 1'b0, 1'b0);
        n_vec++;
        if (fifo_level !== 5) begin
            n_err++; $display("FAIL rst_mid_fill: got level=%0d expected 5", fifo_level);
        end
        drive(ev_word(31'h66), 1'b0, 1'b1);
        n_vec++;
        if (fifo_level !== 0 || cmd_valid !== 1'b0 || overflow_cnt !== 0) begin
            n_err++;
            $display("FAIL rst_mid: got level=%0d valid=%0b ovf=%0d expected 0 0 0",
                     fifo_level, cmd_valid, overflow_cnt);
        end
        drive(32'h8000_0abc, 1'b0, 1'b0);
        n_vec++;
        if (fifo_level !== 1 || cmd_data !== 31'habc) begin
            n_err++;
            $display("FAIL rst_first_ev: got level=%0d data=%h expected level=1 data=abc",
                     fifo_level, cmd_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic        rdy;
        logic        rst;
        for (int i = 0; i < 3000; i++) begin
            w   = {m_prev ^ ($urandom_range(0, 1) == 1), 31'($urandom())};
            rdy = ($urandom_range(0, 9) < 4);
            rst = ($urandom_range(0, 199) == 0);
            drive(w, rdy, rst);
            n_vec++;
            if (cmd_valid !== (m_q.size() != 0) || fifo_level !== m_q.size()
                || overflow_cnt !== CNT_W'(m_ovf)) begin
                n_err++;
                $display("FAIL rand_state@%0d: got valid=%0b level=%0d ovf=%0d expected valid=%0b level=%0d ovf=%0d",
                         i, cmd_valid, fifo_level, overflow_cnt, m_q.size() != 0, m_q.size(), m_ovf);
            end
            if (m_q.size() != 0) begin
                n_vec++;
                if (cmd_data !== m_q[0]) begin
                    n_err++;
                    $display("FAIL rand_data@%0d: got %h expected %h", i, cmd_data, m_q[0]);
                end
            end
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        m_prev    = 1'b0;
        m_ovf     = 0;
        reset     = 1'b1;
        pio_word  = 32'h0;
        cmd_ready = 1'b0;
        test_reset();
        test_basic();
        test_payload_hold();
        test_overflow();
        test_full_pushpop();
        test_empty_pushpop();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
